// File: rtl/mem_access_ctrl_pkg.sv
// Shared pipeline constants for the MEM-stage access controller: load-type
// encodings, controller state encoding and the latched request record.
package mem_access_ctrl_pkg;

   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_LB   = 3'd1;
   localparam logic [2:0] LD_LH   = 3'd2;
   localparam logic [2:0] LD_LW   = 3'd3;
   localparam logic [2:0] LD_LBU  = 3'd4;
   localparam logic [2:0] LD_LHU  = 3'd5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      logic [2:0]  ld_type;
   } mem_req_t;

   function automatic logic is_load(input logic [2:0] ld_type);
      return (ld_type >= LD_LB) && (ld_type <= LD_LHU);
   endfunction

   function automatic logic is_access(input logic [2:0] ld_type, input logic [3:0] we);
      return is_load(ld_type) || (we != 4'd0);
   endfunction

   // A store (or an unused encoding) always extends to zero, so fold it to NONE here.
   function automatic logic [2:0] effective_type(input logic [2:0] ld_type, input logic [3:0] we);
      if ((we != 4'd0) || !is_load(ld_type)) begin
         return LD_NONE;
      end
      return ld_type;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response bus between the MEM-stage controller and backing memory.
interface mem_access_ctrl_if;

   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [3:0]  mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   modport master (
      output mem_req_valid,
      output mem_req_we,
      output mem_req_addr,
      output mem_req_wdata,
      input  mem_req_ready,
      input  mem_resp_valid,
      input  mem_resp_data
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_we,
      input  mem_req_addr,
      input  mem_req_wdata,
      output mem_req_ready,
      output mem_resp_valid,
      output mem_resp_data
   );

endinterface

// File: rtl/mem_access_ctrl_load_extender.sv
// Pure combinational load extractor: picks the byte/halfword addressed by the
// offset out of a memory word and sign- or zero-extends it.
module load_extender
   import mem_access_ctrl_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_offset,
   input  logic [2:0]  i_ld_type,
   output logic [31:0] o_data
);

   logic [7:0]  w_bytes  [4];
   logic [15:0] w_halves [2];
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign w_bytes[gi] = i_word[8*gi +: 8];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half
         assign w_halves[gi] = i_word[16*gi +: 16];
      end
   endgenerate

   // Halfword loads deliberately ignore offset bit 0.
   assign w_byte = w_bytes[i_offset];
   assign w_half = w_halves[i_offset[1]];

   always_comb begin
      o_data = '0;
      case (i_ld_type)
         LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         LD_LBU:  o_data = {24'd0, w_byte};
         LD_LH:   o_data = {{16{w_half[15]}}, w_half};
         LD_LHU:  o_data = {16'd0, w_half};
         LD_LW:   o_data = i_word;
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: stalls the pipeline while a single load or
// store is carried over a valid/ready request bus to backing memory.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  load_type_MEM,
   input  logic [3:0]  cache_write_en_MEM,
   input  logic [31:0] addr_MEM,
   input  logic [31:0] store_data_MEM,
   output logic        stall_MEM,
   output logic [31:0] load_data_MEM,
   mem_access_ctrl_if.master mem
);

   logic [1:0]  r_state;
   logic [1:0]  w_state_next;
   mem_req_t    r_req;
   logic [31:0] r_resp_word;
   logic [31:0] r_load_hold;
   logic        w_access;
   logic        w_busy;
   logic        w_launch;
   logic        w_capture;
   logic [31:0] w_ext_data;

   assign w_access  = is_access(load_type_MEM, cache_write_en_MEM);
   assign w_busy    = (r_state == ST_REQ) || (r_state == ST_WAIT);
   assign w_launch  = (r_state == ST_IDLE) && w_access;
   assign w_capture = w_busy && mem.mem_resp_valid;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_access) begin
               w_state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem.mem_req_ready) begin
               w_state_next = mem.mem_resp_valid ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem.mem_resp_valid) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_req       <= '0;
         r_resp_word <= '0;
         r_load_hold <= '0;
      end else begin
         r_state <= w_state_next;
         // The request is frozen here; pipeline inputs are ignored until DONE.
         if (w_launch) begin
            r_req.addr    <= addr_MEM;
            r_req.we      <= cache_write_en_MEM;
            r_req.wdata   <= store_data_MEM;
            r_req.ld_type <= effective_type(load_type_MEM, cache_write_en_MEM);
         end
         if (w_capture) begin
            r_resp_word <= mem.mem_resp_data;
         end
         if (r_state == ST_DONE) begin
            r_load_hold <= w_ext_data;
         end
      end
   end

   load_extender u_load_extender (
      .i_word    (r_resp_word),
      .i_offset  (r_req.addr[1:0]),
      .i_ld_type (r_req.ld_type),
      .o_data    (w_ext_data)
   );

   assign stall_MEM     = w_launch || w_busy;
   assign load_data_MEM = (r_state == ST_DONE) ? w_ext_data : r_load_hold;

   assign mem.mem_req_valid = (r_state == ST_REQ);
   assign mem.mem_req_we    = r_req.we;
   assign mem.mem_req_addr  = {r_req.addr[31:2], 2'b00};
   assign mem.mem_req_wdata = r_req.wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a transaction-timing model predicts every
// cycle's outputs and a single negedge process compares them.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  load_type_MEM;
   logic [3:0]  cache_write_en_MEM;
   logic [31:0] addr_MEM;
   logic [31:0] store_data_MEM;
   logic        stall_MEM;
   logic [31:0] load_data_MEM;

   mem_access_ctrl_if mif();

   mem_access_ctrl dut (
      .clk                (clk),
      .rst                (rst),
      .load_type_MEM      (load_type_MEM),
      .cache_write_en_MEM (cache_write_en_MEM),
      .addr_MEM           (addr_MEM),
      .store_data_MEM     (store_data_MEM),
      .stall_MEM          (stall_MEM),
      .load_data_MEM      (load_data_MEM),
      .mem                (mif)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_err    = 0;
   string       cur_tag  = "init";

   logic        exp_chk  = 1'b0;
   logic        exp_stall;
   logic        exp_rv;
   logic [31:0] exp_addr;
   logic [3:0]  exp_we;
   logic [31:0] exp_wdata;
   logic [31:0] exp_ld;
   logic [31:0] last_ld;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s %s: got 0x%08h required 0x%08h", cur_tag, nm, act, req);
      end
   endtask

   // Spec-level extension rule: shift the addressed lane down, then extend.
   function automatic logic [31:0] exp_load(input logic [2:0] t, input logic [3:0] we,
                                            input logic [31:0] a, input logic [31:0] w);
      logic [31:0]        sh;
      logic signed [7:0]  sb;
      logic signed [15:0] sbh;
      int                 v;
      if (we != 4'd0) return 32'd0;
      sh = w >> (8 * a[1:0]);
      case (t)
         3'd1: begin sb = sh[7:0]; v = sb; return 32'(v); end
         3'd4: return {24'd0, sh[7:0]};
         3'd2: begin sh = w >> (16 * a[1]); sbh = sh[15:0]; v = sbh; return 32'(v); end
         3'd5: begin sh = w >> (16 * a[1]); return {16'd0, sh[15:0]}; end
         3'd3: return w;
         default: return 32'd0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (exp_chk) begin
         check("stall_MEM", {31'd0, stall_MEM}, {31'd0, exp_stall});
         check("mem_req_valid", {31'd0, mif.mem_req_valid}, {31'd0, exp_rv});
         if (exp_rv) begin
            check("mem_req_addr", mif.mem_req_addr, exp_addr);
            check("mem_req_we", {28'd0, mif.mem_req_we}, {28'd0, exp_we});
            check("mem_req_wdata", mif.mem_req_wdata, exp_wdata);
         end
         check("load_data_MEM", load_data_MEM, exp_ld);
      end
   end

   task automatic idle(input int n, input logic [2:0] t, input logic pulse);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         load_type_MEM      = t;
         cache_write_en_MEM = 4'd0;
         addr_MEM           = 32'h0000_0F00 + 32'(k);
         mif.mem_req_ready  = 1'b0;
         mif.mem_resp_valid = pulse;
         mif.mem_resp_data  = 32'hA5A5_0000 + 32'(k);
         exp_stall = 1'b0;
         exp_rv    = 1'b0;
         exp_ld    = last_ld;
         exp_chk   = 1'b1;
      end
   endtask

   // Cycle 0 presents the access; memory accepts after rdy_dly extra REQ cycles
   // and responds rsp_dly cycles after acceptance; DONE follows the response.
   task automatic run_txn(input string tag, input logic [2:0] t, input logic [3:0] we,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int rdy_dly, input int rsp_dly, input logic perturb,
                          input logic [31:0] lit);
      int n_stall;
      logic [31:0] e;
      n_stall = 2 + rdy_dly + rsp_dly;
      e = exp_load(t, we, a, rd);
      cur_tag = tag;
      for (int k = 0; k <= n_stall; k++) begin
         @(posedge clk); #1;
         load_type_MEM      = t;
         cache_write_en_MEM = we;
         addr_MEM           = (perturb && k > 0) ? (a ^ (32'h0000_1110 * 32'(k))) : a;
         store_data_MEM     = (perturb && k > 0) ? ~wd : wd;
         mif.mem_req_ready  = (k == 1 + rdy_dly);
         mif.mem_resp_valid = (k == 1 + rdy_dly + rsp_dly);
         mif.mem_resp_data  = mif.mem_resp_valid ? rd : $urandom();
         exp_stall = (k < n_stall);
         exp_rv    = (k >= 1) && (k <= 1 + rdy_dly);
         exp_addr  = {a[31:2], 2'b00};
         exp_we    = we;
         exp_wdata = wd;
         if (k == n_stall) last_ld = e;
         exp_ld    = last_ld;
         exp_chk   = 1'b1;
      end
      @(negedge clk); #1;
      check("done_literal", load_data_MEM, lit);
      $display("txn %s type=%0d we=%b addr=0x%08h resp=0x%08h load_data=0x%08h",
               tag, t, we, a, rd, load_data_MEM);
   endtask

   initial begin
      rst                = 1'b1;
      load_type_MEM      = 3'd0;
      cache_write_en_MEM = 4'd0;
      addr_MEM           = 32'd0;
      store_data_MEM     = 32'd0;
      mif.mem_req_ready  = 1'b0;
      mif.mem_resp_valid = 1'b0;
      mif.mem_resp_data  = 32'd0;
      last_ld            = 32'd0;

      repeat (2) @(posedge clk);
      #1;
      cur_tag   = "reset";
      exp_stall = 1'b0;
      exp_rv    = 1'b0;
      exp_ld    = 32'd0;
      exp_chk   = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2, 3'd0, 1'b0);

      run_txn("lw_0x100",  3'd3, 4'd0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 1'b0, 32'hDEADBEEF);
      run_txn("lb_0x203",  3'd1, 4'd0, 32'h203, 32'h0, 32'h80FFFF7F, 0, 1, 1'b0, 32'hFFFFFF80);
      run_txn("lbu_0x203", 3'd4, 4'd0, 32'h203, 32'h0, 32'h80FFFF7F, 0, 1, 1'b0, 32'h00000080);
      run_txn("lh_0x102",  3'd2, 4'd0, 32'h102, 32'h0, 32'h80011234, 0, 1, 1'b0, 32'hFFFF8001);
      run_txn("lhu_0x102", 3'd5, 4'd0, 32'h102, 32'h0, 32'h80011234, 0, 1, 1'b0, 32'h00008001);
      idle(2, 3'd6, 1'b1);
      run_txn("sb_0x6", 3'd0, 4'b0100, 32'h6, 32'h00AB0000, 32'h12345678, 4, 1, 1'b1, 32'h0);
      idle(1, 3'd7, 1'b1);
      run_txn("lh_same_cyc", 3'd2, 4'd0, 32'h100, 32'h0, 32'h00007FFE, 0, 0, 1'b0, 32'h00007FFE);
      run_txn("lb_off0",  3'd1, 4'd0, 32'h40, 32'h0, 32'h44332281, 1, 2, 1'b0, 32'hFFFFFF81);
      run_txn("lb_off1",  3'd1, 4'd0, 32'h41, 32'h0, 32'h44332281, 2, 0, 1'b0, 32'h00000022);
      run_txn("lbu_off2", 3'd4, 4'd0, 32'h42, 32'h0, 32'h44F32281, 0, 1, 1'b0, 32'h000000F3);
      run_txn("lh_0x103", 3'd2, 4'd0, 32'h103, 32'h0, 32'h7FFF8000, 0, 1, 1'b1, 32'h00007FFF);
      run_txn("lw_0x7",   3'd3, 4'd0, 32'h7, 32'h0, 32'h0BADF00D, 3, 0, 1'b0, 32'h0BADF00D);
      run_txn("sw_full",  3'd0, 4'b1111, 32'h80, 32'hCAFEF00D, 32'hFFFFFFFF, 0, 1, 1'b0, 32'h0);
      idle(1, 3'd0, 1'b0);
      run_txn("b2b_lw_a", 3'd3, 4'd0, 32'h200, 32'h0, 32'h11112222, 0, 1, 1'b0, 32'h11112222);
      run_txn("b2b_lw_b", 3'd3, 4'd0, 32'h204, 32'h0, 32'h33334444, 1, 1, 1'b0, 32'h33334444);

      // Reset lands while the controller waits for a response; the late
      // response must not revive the abandoned load.
      cur_tag = "rst_wait";
      @(posedge clk); #1;
      load_type_MEM = 3'd3; cache_write_en_MEM = 4'd0; addr_MEM = 32'h300; store_data_MEM = 32'h0;
      mif.mem_req_ready = 1'b0; mif.mem_resp_valid = 1'b0;
      exp_stall = 1'b1; exp_rv = 1'b0; exp_ld = last_ld;
      @(posedge clk); #1;
      mif.mem_req_ready = 1'b1;
      exp_stall = 1'b1; exp_rv = 1'b1; exp_addr = 32'h300; exp_we = 4'd0; exp_wdata = 32'h0;
      @(posedge clk); #1;
      mif.mem_req_ready = 1'b0;
      rst = 1'b1;
      load_type_MEM = 3'd0;
      exp_stall = 1'b1; exp_rv = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      mif.mem_resp_valid = 1'b1; mif.mem_resp_data = 32'h55555555;
      last_ld = 32'd0;
      exp_stall = 1'b0; exp_rv = 1'b0; exp_ld = 32'd0;
      @(negedge clk); #1;
      check("rst_stall_literal", {31'd0, stall_MEM}, 32'd0);
      $display("txn rst_wait stall=%0d load_data=0x%08h", stall_MEM, load_data_MEM);
      idle(3, 3'd0, 1'b0);

      run_txn("post_rst_lhu", 3'd5, 4'd0, 32'h302, 32'h0, 32'hBEEF0001, 0, 1, 1'b0, 32'h0000BEEF);
      idle(2, 3'd0, 1'b0);

      @(posedge clk); #1;
      exp_chk = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
